// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter plus in-order instruction queue feeding decode.
// Optional EARLY_JUMP_EN: j/jal words steer fetch_pc at push time.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d, pc_plus4;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic          push, pop;

    assign imem_pc     = fetch_pc_q;
    assign if_valid    = count_q != '0;
    assign pop         = if_valid & if_ready;
    assign push        = fetch_en & ~redirect_valid & ((count_q < FULL) | pop);
    assign if_instr    = if_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign if_pc       = if_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign if_pc_plus4 = if_valid ? pc_mem_q[rd_ptr_q] + 32'd4 : '0;

    always_comb begin
        pc_plus4 = fetch_pc_q + 32'd4;
`ifdef EARLY_JUMP_EN
        // opcodes 000010 (j) and 000011 (jal) share the top five bits
        fetch_pc_d = (imem_instr[31:27] == 5'b00001) ?
                     {pc_plus4[31:28], imem_instr[25:0], 2'b00} : pc_plus4;
`else
        fetch_pc_d = pc_plus4;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else if (redirect_valid) begin
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (push) begin
                fetch_pc_q <= fetch_pc_d;
                wr_ptr_q   <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only observed through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_instr;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus hand-written reset sequences.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, fetch_en, redirect_valid, if_ready;
    logic [31:0] redirect_pc, imem_pc, imem_instr, if_instr, if_pc, if_pc_plus4;
    logic        if_valid;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        en;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eimem;
    } vec_t;

    vec_t v [19];

    instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_pc(imem_pc),
        .imem_instr(imem_instr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0)  return 32'h8C02_0000;
        if (a == 32'h40) return 32'h0800_0014;
        if (a == 32'h50) return 32'h0C00_0018;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_instr = mem(imem_pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        // Outputs are sampled 1ns after each edge; inputs change on the falling edge.
        v[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8};
        v[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8};
        v[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'hC};
        v[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h10};
        v[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         32'h10};
        v[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h10};
        v[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h10};
        v[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        32'h14};
        v[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14,        32'h18};
        v[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h14,        32'h1C};
        v[10] = '{1'b1, 1'b1, 32'h13,        1'b1, 1'b0, 32'h0,         32'h10};
        v[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10,        32'h14};
        v[12] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         32'hFFFF_FFFC};
        v[13] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0};
        v[14] = '{1'b1, 1'b1, 32'h40,        1'b1, 1'b0, 32'h0,         32'h40};
`ifdef EARLY_JUMP_EN
        v[15] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        32'h50};
        v[17] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h50,        32'h60};
`else
        v[15] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        32'h44};
        v[17] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h50,        32'h54};
`endif
        v[16] = '{1'b1, 1'b1, 32'h50,        1'b1, 1'b0, 32'h0,         32'h50};
        v[18] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h50,        32'h58};
`ifdef EARLY_JUMP_EN
        v[18].eimem = 32'h64;
`endif
        rst_n = 1'b0;
        fetch_en = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", {31'b0, if_valid}, 32'h0);
        chk("reset_imem_pc", imem_pc, 32'h0);
        chk("reset_if_pc", if_pc, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_valid", {31'b0, if_valid}, 32'h1);
        chk("first_pc", if_pc, 32'h0);
        chk("first_instr", if_instr, 32'h8C02_0000);
        chk("first_pc4", if_pc_plus4, 32'h4);
        chk("first_imem", imem_pc, 32'h4);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            fetch_en = v[i].en;
            redirect_valid = v[i].rv;
            redirect_pc = v[i].rpc;
            if_ready = v[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, v[i].ev});
            chk($sformatf("v%0d_imem", i), imem_pc, v[i].eimem);
            if (v[i].ev) begin
                chk($sformatf("v%0d_pc", i), if_pc, v[i].epc);
                chk($sformatf("v%0d_instr", i), if_instr, mem(v[i].epc));
                chk($sformatf("v%0d_pc4", i), if_pc_plus4, v[i].epc + 32'd4);
            end
        end
        // Two entries are queued here; asynchronous reset must drop them between edges.
        @(negedge clk);
        redirect_valid = 1'b0;
        if_ready = 1'b0;
        fetch_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, if_valid}, 32'h0);
        chk("async_imem", imem_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rerun_valid", {31'b0, if_valid}, 32'h1);
        chk("rerun_pc", if_pc, 32'h0);
        chk("rerun_instr", if_instr, 32'h8C02_0000);
        chk("rerun_imem", imem_pc, 32'h4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
